ppu_scroll_regs: RTL
====================

PPU_SCROLL_REGS -- requirements
Module: ppu_scroll_regs

Interface
REQ-001 Parameter: none; all widths fixed.
REQ-002 clk  input  1  PPU master clock.
REQ-003 rst_n  input  1  reset: asynchronous, active-low.
REQ-004 clk_en  input  1  pixel-rate enable; qualifies scroll/update strobes only.
REQ-005 reg_wr_en  input  1  one-cycle CPU register write pulse.
REQ-006 reg_rd_en  input  1  one-cycle CPU register read pulse.
REQ-007 reg_sel  input  3  register index 0-7 ($2000-$2007).
REQ-008 reg_wdata  input  8  CPU write data.
REQ-009 render_en  input  1  background or sprite rendering enabled (PPUMASK).
REQ-010 h_scroll, v_scroll, h_update, v_update  input  1 each  strobes from the background pixel stage.
REQ-011 vAddr  output  16  current VRAM address v; bit 15 always 0.
REQ-012 fX  output  3  fine X scroll.
REQ-013 w_toggle  output  1  first/second write latch.
REQ-014 t_addr  output  15  temporary address t (debug/visibility).

Function
REQ-015 Registered state: v[14:0], t[14:0], fX, w, inc32 (PPUCTRL bit 2); all outputs driven directly from flops.
REQ-016 $2000 write: t[11:10] <= d[1:0]; inc32 <= d[2]; w unchanged.
REQ-017 $2002 read: w <= 0; nothing else changes.
REQ-018 $2005 write, w=0: t[4:0] <= d[7:3]; fX <= d[2:0]; w <= 1.
REQ-019 $2005 write, w=1: t[14:12] <= d[2:0]; t[9:5] <= d[7:3]; w <= 0.
REQ-020 $2006 write, w=0: t[13:8] <= d[5:0]; t[14] <= 0; w <= 1.
REQ-021 $2006 write, w=1: t[7:0] <= d; v <= new t (same cycle, 1-cycle latency to vAddr); w <= 0.
REQ-022 $2007 read or write: v <= (v + (inc32 ? 32 : 1)) mod 2^15.
REQ-023 Register accesses are sampled every clk, independent of clk_en; writes/reads to other indices ignored.
REQ-024 h_scroll (with clk_en): if v[4:0]==31 then v[4:0] <= 0, v[10] flips; else v[4:0] += 1.
REQ-025 v_scroll (with clk_en): if v[14:12]!=7, fine Y += 1; else fine Y <= 0 and coarse Y (v[9:5]) steps: 29 -> 0 with v[11] flip; 31 -> 0 without flip; otherwise +1.
REQ-026 h_update (with clk_en): v[10] <= t[10]; v[4:0] <= t[4:0].
REQ-027 v_update (with clk_en): v[14:11] <= t[14:11]; v[9:5] <= t[9:5].
REQ-028 Simultaneous strobes touching disjoint fields all apply; h_update overrides h_scroll; v_update overrides v_scroll.
REQ-029 Any CPU access that writes v ($2006 second write, $2007) in the same cycle as a strobe takes priority over every strobe.
REQ-030 vAddr = {1'b0, v}.

Reset
REQ-031 On rst_n low: v, t = 0; fX = 0; w = 0; inc32 = 0; takes effect immediately regardless of clk.
REQ-032 Reset mid-sequence (after first $2005/$2006 write) clears w; next write is a first write.

Configuration
REQ-033 Macro SCROLL_RENDER_GATE_EN: when defined, REQ-024..027 apply only when render_en=1, otherwise strobes are ignored; when undefined, strobes apply regardless of render_en.

Verification
REQ-034 $2006 <= 0x21, $2006 <= 0x08 -> vAddr=0x2108, w=0; t=0x2108.
REQ-035 $2005 <= 0x7D, $2005 <= 0x5E -> fX=5, t[4:0]=15, t[14:12]=6, t[9:5]=11, w=0; $2002 read between writes resets w.
REQ-036 v=0x001F, h_scroll with clk_en -> v=0x0400; same with clk_en=0 -> v unchanged.
REQ-037 v=0x73A0 (fineY 7, coarseY 29), v_scroll -> v=0x0800; v=0x73E0 (coarseY 31) -> v=0x0000.
REQ-038 $2000 <= 0x04, v=0x7FF0, $2007 write -> v=0x0010 (wrap); $2007 write same cycle as h_scroll -> only +32 applied.
REQ-039 SCROLL_RENDER_GATE_EN defined, render_en=0, h_update -> v unchanged; render_en=1 -> v[10], v[4:0] copied from t.

Source files
------------

// File: rtl/ppu_scroll_regs.sv
// ppu_scroll_regs: PPU loopy scroll/address registers (v, t, fine X, write latch).
//   CPU side : reg_wr_en/reg_rd_en pulses with reg_sel ($2000-$2007) and reg_wdata,
//              sampled every clk regardless of clk_en.
//   Render   : h_scroll/v_scroll/h_update/v_update strobes, qualified by clk_en.
//   Outputs  : vAddr ({1'b0, v}), fX, w_toggle, t_addr, all straight from flops.
//   Reset    : rst_n, asynchronous, active-low.
//   Option   : define SCROLL_RENDER_GATE_EN to ignore the render strobes
//              whenever render_en is low.
module ppu_scroll_regs (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        clk_en,
  input  logic        reg_wr_en,
  input  logic        reg_rd_en,
  input  logic [2:0]  reg_sel,
  input  logic [7:0]  reg_wdata,
  input  logic        render_en,
  input  logic        h_scroll,
  input  logic        v_scroll,
  input  logic        h_update,
  input  logic        v_update,
  output logic [15:0] vAddr,
  output logic [2:0]  fX,
  output logic        w_toggle,
  output logic [14:0] t_addr
);

  localparam int unsigned ADDR_W = 15;
  localparam int unsigned FINE_W = 3;

  logic [ADDR_W-1:0] v_q, v_d, t_q, t_d, v_strb;
  logic [FINE_W-1:0] fx_q, fx_d;
  logic              w_q, w_d;
  logic              inc32_q, inc32_d;

  logic strobe_en;
  logic wr_ctrl, wr_scroll, wr_addr, rd_status, data_acc;

`ifdef SCROLL_RENDER_GATE_EN
  assign strobe_en = clk_en & render_en;
`else
  logic unused_render_en;
  assign unused_render_en = render_en;
  assign strobe_en = clk_en;
`endif

  // Register access decode
  assign wr_ctrl   = reg_wr_en && (reg_sel == 3'd0);
  assign wr_scroll = reg_wr_en && (reg_sel == 3'd5);
  assign wr_addr   = reg_wr_en && (reg_sel == 3'd6);
  assign rd_status = reg_rd_en && (reg_sel == 3'd2);
  assign data_acc  = (reg_wr_en || reg_rd_en) && (reg_sel == 3'd7);

  // Render-side v update: horizontal fields {v[10], v[4:0]}, vertical fields
  // {v[14:11], v[9:5]} are disjoint so both halves may apply in one cycle.
  always_comb begin
    v_strb = v_q;
    if (strobe_en) begin
      if (h_update) begin
        v_strb[10]  = t_q[10];
        v_strb[4:0] = t_q[4:0];
      end else if (h_scroll) begin
        if (v_q[4:0] == 5'd31) begin
          v_strb[4:0] = 5'd0;
          v_strb[10]  = ~v_q[10];
        end else begin
          v_strb[4:0] = v_q[4:0] + 5'd1;
        end
      end

      if (v_update) begin
        v_strb[14:11] = t_q[14:11];
        v_strb[9:5]   = t_q[9:5];
      end else if (v_scroll) begin
        if (v_q[14:12] != 3'd7) begin
          v_strb[14:12] = v_q[14:12] + 3'd1;
        end else begin
          v_strb[14:12] = 3'd0;
          // Row 29 is the last visible tile row; 30/31 are attribute space
          // and wrap without switching nametables.
          case (v_q[9:5])
            5'd29: begin
              v_strb[9:5] = 5'd0;
              v_strb[11]  = ~v_q[11];
            end
            5'd31:   v_strb[9:5] = 5'd0;
            default: v_strb[9:5] = v_q[9:5] + 5'd1;
          endcase
        end
      end
    end
  end

  // CPU register side; v writes from the CPU win over render strobes.
  always_comb begin
    t_d     = t_q;
    fx_d    = fx_q;
    w_d     = w_q;
    inc32_d = inc32_q;
    v_d     = v_strb;

    if (wr_ctrl) begin
      t_d[11:10] = reg_wdata[1:0];
      inc32_d    = reg_wdata[2];
    end

    if (wr_scroll) begin
      if (!w_q) begin
        t_d[4:0] = reg_wdata[7:3];
        fx_d     = reg_wdata[2:0];
        w_d      = 1'b1;
      end else begin
        t_d[14:12] = reg_wdata[2:0];
        t_d[9:5]   = reg_wdata[7:3];
        w_d        = 1'b0;
      end
    end

    if (wr_addr) begin
      if (!w_q) begin
        t_d[13:8] = reg_wdata[5:0];
        t_d[14]   = 1'b0;
        w_d       = 1'b1;
      end else begin
        t_d[7:0] = reg_wdata;
        v_d      = {t_q[14:8], reg_wdata};
        w_d      = 1'b0;
      end
    end

    if (rd_status) begin
      w_d = 1'b0;
    end

    if (data_acc) begin
      v_d = v_q + (inc32_q ? ADDR_W'(32) : ADDR_W'(1));
    end
  end

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      v_q     <= '0;
      t_q     <= '0;
      fx_q    <= '0;
      w_q     <= 1'b0;
      inc32_q <= 1'b0;
    end else begin
      v_q     <= v_d;
      t_q     <= t_d;
      fx_q    <= fx_d;
      w_q     <= w_d;
      inc32_q <= inc32_d;
    end
  end

  assign vAddr    = {1'b0, v_q};
  assign fX       = fx_q;
  assign w_toggle = w_q;
  assign t_addr   = t_q;

endmodule
